// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: ALU control encoding, result-source
// encoding, forward-select enum and the register-match helper used by the
// execute-stage operand forwarding.
package riscv_pkg;

  localparam int unsigned REG_IDX_W = 5;

  // ALU control encoding carried from decode into execute.
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SLL = 3'b111
  } alu_op_e;

  // Writeback result source: ALU result, load data, or PC+4 (jumps).
  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC4  = 2'b10,
    RES_RSVD = 2'b11
  } result_src_e;

  // Operand source chosen by the forwarding logic.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // A later stage supplies a source operand only when it writes a register,
  // targets the same index, and that index is not x0 (x0 always reads zero
  // from the register file, so it must never be overridden).
  function automatic logic src_match(input logic                 reg_write,
                                     input logic [REG_IDX_W-1:0] rd,
                                     input logic [REG_IDX_W-1:0] rs);
    return reg_write && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/ex_operand_stage_forward_unit.sv
// Per-operand forwarding mux: picks the freshest value of one source
// register from the MEM stage, the WB stage, or the value held in EX.
// MEM is younger than WB, so it wins when both target the same register.
module forward_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [REG_IDX_W-1:0] rs,
  input  logic [XLEN-1:0]      stored,
  input  logic                 mem_reg_write,
  input  logic [REG_IDX_W-1:0] mem_rd,
  input  logic [XLEN-1:0]      mem_alu_result,
  input  logic                 wb_reg_write,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_result,
  output logic [XLEN-1:0]      value
);

  fwd_sel_e sel;

  // Select the source: MEM match overrides WB match, which overrides the held value.
  always_comb begin
    sel = FWD_REG;
    if (src_match(wb_reg_write, wb_rd, rs)) begin
      sel = FWD_WB;
    end
    if (src_match(mem_reg_write, mem_rd, rs)) begin
      sel = FWD_MEM;
    end
  end

  // Drive the operand value from the selected source.
  always_comb begin
    value = stored;
    case (sel)
      FWD_MEM: value = mem_alu_result;
      FWD_WB:  value = wb_result;
      default: value = stored;
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// Execute-stage operand register: holds one decoded instruction, forwards
// fresh operand values from MEM/WB, inserts a single bubble on load-use, and
// keeps held operands current while the instruction waits downstream.
//
// Handshake: a transfer on either side happens on a rising clk edge where
// valid and ready are both 1. id_valid/id_* must stay stable until id_ready
// is seen; ex_valid/ex_* are stable while ex_valid=1 and ex_ready=0, except
// that operand values may change when a retiring producer's result is
// forwarded (the freshest value is always presented). id_ready is
// combinational: the slot is free when empty or when its occupant leaves
// this cycle. flush_e overrides everything and empties the slot.
module ex_operand_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  // decode -> execute
  input  logic                 id_valid,
  output logic                 id_ready,
  input  logic [XLEN-1:0]      id_rd1,
  input  logic [XLEN-1:0]      id_rd2,
  input  logic [XLEN-1:0]      id_imm_ext,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic [2:0]           id_alu_control,
  input  logic                 id_alu_src,
  input  logic                 id_reg_write,
  input  logic                 id_mem_write,
  input  logic [1:0]           id_result_src,
  // pipeline control
  input  logic                 flush_e,
  input  logic                 ex_ready,
  // MEM-stage forwarding sources
  input  logic                 mem_reg_write,
  input  logic [REG_IDX_W-1:0] mem_rd,
  input  logic [XLEN-1:0]      mem_alu_result,
  input  logic                 mem_is_load,
  // WB-stage forwarding sources
  input  logic                 wb_reg_write,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_result,
  // execute outputs
  output logic                 ex_valid,
  output logic [XLEN-1:0]      SrcA,
  output logic [XLEN-1:0]      SrcB,
  output logic [XLEN-1:0]      ex_write_data,
  output logic [2:0]           ALUControl,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic                 ex_reg_write,
  output logic                 ex_mem_write,
  output logic [1:0]           ex_result_src
);

  // Held instruction
  logic                 valid_reg;
  logic [XLEN-1:0]      rd1_reg;
  logic [XLEN-1:0]      rd2_reg;
  logic [XLEN-1:0]      imm_reg;
  logic [REG_IDX_W-1:0] rs1_reg;
  logic [REG_IDX_W-1:0] rs2_reg;
  logic [REG_IDX_W-1:0] rd_reg;
  alu_op_e              alu_control_reg;
  logic                 alu_src_reg;
  logic                 reg_write_reg;
  logic                 mem_write_reg;
  result_src_e          result_src_reg;

  // Forwarded operands and handshake terms
  logic [XLEN-1:0]      fwd_rs1;
  logic [XLEN-1:0]      fwd_rs2;
  logic                 rs2_used;
  logic                 load_use;
  logic                 fire;
  logic                 capture;

  forward_unit #(.XLEN(XLEN)) u_fwd_rs1 (
    .rs             (rs1_reg),
    .stored         (rd1_reg),
    .mem_reg_write  (mem_reg_write),
    .mem_rd         (mem_rd),
    .mem_alu_result (mem_alu_result),
    .wb_reg_write   (wb_reg_write),
    .wb_rd          (wb_rd),
    .wb_result      (wb_result),
    .value          (fwd_rs1)
  );

  forward_unit #(.XLEN(XLEN)) u_fwd_rs2 (
    .rs             (rs2_reg),
    .stored         (rd2_reg),
    .mem_reg_write  (mem_reg_write),
    .mem_rd         (mem_rd),
    .mem_alu_result (mem_alu_result),
    .wb_reg_write   (wb_reg_write),
    .wb_rd          (wb_rd),
    .wb_result      (wb_result),
    .value          (fwd_rs2)
  );

  // rs2 is a real dependency only when it feeds the ALU or is store data.
  assign rs2_used = !alu_src_reg || mem_write_reg;

  // A load in MEM has only its address on mem_alu_result; the data arrives
  // in WB next cycle, so a dependent instruction waits exactly one cycle.
  assign load_use = valid_reg && mem_is_load && mem_reg_write && (mem_rd != '0) &&
                    ((mem_rd == rs1_reg) || ((mem_rd == rs2_reg) && rs2_used));

  assign ex_valid = valid_reg && !load_use;
  assign fire     = ex_valid && ex_ready;
  assign id_ready = !valid_reg || fire;
  assign capture  = id_valid && id_ready && !flush_e;

  // Slot update: reset, then flush, then capture, then drain on fire; a
  // waiting instruction refreshes its operands so a producer that retires
  // during the wait is not lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_reg       <= 1'b0;
      rd1_reg         <= '0;
      rd2_reg         <= '0;
      imm_reg         <= '0;
      rs1_reg         <= '0;
      rs2_reg         <= '0;
      rd_reg          <= '0;
      alu_control_reg <= ALU_ADD;
      alu_src_reg     <= 1'b0;
      reg_write_reg   <= 1'b0;
      mem_write_reg   <= 1'b0;
      result_src_reg  <= RES_ALU;
    end else if (flush_e) begin
      valid_reg <= 1'b0;
    end else if (capture) begin
      valid_reg       <= 1'b1;
      rd1_reg         <= id_rd1;
      rd2_reg         <= id_rd2;
      imm_reg         <= id_imm_ext;
      rs1_reg         <= id_rs1;
      rs2_reg         <= id_rs2;
      rd_reg          <= id_rd;
      alu_control_reg <= alu_op_e'(id_alu_control);
      alu_src_reg     <= id_alu_src;
      reg_write_reg   <= id_reg_write;
      mem_write_reg   <= id_mem_write;
      result_src_reg  <= result_src_e'(id_result_src);
    end else if (fire) begin
      valid_reg <= 1'b0;
    end else if (valid_reg) begin
      rd1_reg <= fwd_rs1;
      rd2_reg <= fwd_rs2;
    end
  end

  // Operand outputs: immediate replaces rs2 on the ALU B input only.
  assign SrcA          = fwd_rs1;
  assign SrcB          = alu_src_reg ? imm_reg : fwd_rs2;
  assign ex_write_data = fwd_rs2;

  // Control outputs; side-effecting writes are suppressed during bubbles.
  assign ALUControl    = alu_control_reg;
  assign ex_rd         = rd_reg;
  assign ex_reg_write  = reg_write_reg && ex_valid;
  assign ex_mem_write  = mem_write_reg && ex_valid;
  assign ex_result_src = result_src_reg;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed scenarios plus randomized traffic
// checked against a behavioural model of the execute slot.
module tb_ex_operand_stage;

  localparam int XLEN = 32;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // DUT signals
  logic            id_valid, id_ready;
  logic [XLEN-1:0] id_rd1, id_rd2, id_imm_ext;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic [2:0]      id_alu_control;
  logic            id_alu_src, id_reg_write, id_mem_write;
  logic [1:0]      id_result_src;
  logic            flush_e, ex_ready;
  logic            mem_reg_write, mem_is_load;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_alu_result;
  logic            wb_reg_write;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_result;
  logic            ex_valid;
  logic [XLEN-1:0] SrcA, SrcB, ex_write_data;
  logic [2:0]      ALUControl;
  logic [4:0]      ex_rd;
  logic            ex_reg_write, ex_mem_write;
  logic [1:0]      ex_result_src;

  int total = 0;
  int bad   = 0;
  logic [XLEN-1:0] exp_q[$];

  ex_operand_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm_ext(id_imm_ext),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_alu_control(id_alu_control), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_write(id_mem_write),
    .id_result_src(id_result_src),
    .flush_e(flush_e), .ex_ready(ex_ready),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_alu_result(mem_alu_result), .mem_is_load(mem_is_load),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_valid(ex_valid), .SrcA(SrcA), .SrcB(SrcB), .ex_write_data(ex_write_data),
    .ALUControl(ALUControl), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_write(ex_mem_write), .ex_result_src(ex_result_src)
  );

  // ---------------- reference model ----------------
  logic            m_valid;
  logic [XLEN-1:0] m_rd1, m_rd2, m_imm;
  logic [4:0]      m_rs1, m_rs2, m_rd;
  logic [2:0]      m_alu;
  logic            m_alu_src, m_rw, m_mw;
  logic [1:0]      m_res;

  // Freshest architectural value of register rs as seen from EX.
  function automatic logic [XLEN-1:0] m_fwd(input logic [4:0] rs, input logic [XLEN-1:0] stored);
    if (rs != 5'd0 && mem_reg_write && mem_rd == rs) return mem_alu_result;
    if (rs != 5'd0 && wb_reg_write && wb_rd == rs) return wb_result;
    return stored;
  endfunction

  function automatic logic m_load_use();
    return m_valid && mem_is_load && mem_reg_write && mem_rd != 5'd0 &&
           (mem_rd == m_rs1 || (mem_rd == m_rs2 && (!m_alu_src || m_mw)));
  endfunction

  function automatic logic m_ex_valid();
    return m_valid && !m_load_use();
  endfunction

  function automatic logic m_id_ready();
    return !m_valid || (m_ex_valid() && ex_ready);
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_valid <= 1'b0; m_rd1 <= '0; m_rd2 <= '0; m_imm <= '0;
      m_rs1 <= '0; m_rs2 <= '0; m_rd <= '0; m_alu <= '0;
      m_alu_src <= 1'b0; m_rw <= 1'b0; m_mw <= 1'b0; m_res <= '0;
    end else if (flush_e) begin
      m_valid <= 1'b0;
    end else if (id_valid && m_id_ready()) begin
      m_valid <= 1'b1; m_rd1 <= id_rd1; m_rd2 <= id_rd2; m_imm <= id_imm_ext;
      m_rs1 <= id_rs1; m_rs2 <= id_rs2; m_rd <= id_rd; m_alu <= id_alu_control;
      m_alu_src <= id_alu_src; m_rw <= id_reg_write; m_mw <= id_mem_write;
      m_res <= id_result_src;
    end else if (m_ex_valid() && ex_ready) begin
      m_valid <= 1'b0;
    end else if (m_valid) begin
      m_rd1 <= m_fwd(m_rs1, m_rd1);
      m_rd2 <= m_fwd(m_rs2, m_rd2);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    reset_n = 1'b1; id_valid = 1'b0; id_rd1 = '0; id_rd2 = '0; id_imm_ext = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_alu_control = '0; id_alu_src = 1'b0;
    id_reg_write = 1'b0; id_mem_write = 1'b0; id_result_src = '0;
    flush_e = 1'b0; ex_ready = 1'b1;
    mem_reg_write = 1'b0; mem_rd = '0; mem_alu_result = '0; mem_is_load = 1'b0;
    wb_reg_write = 1'b0; wb_rd = '0; wb_result = '0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [XLEN-1:0] rd1,
                       input logic [4:0] rs2, input logic [XLEN-1:0] rd2,
                       input logic [XLEN-1:0] imm, input logic [4:0] rd,
                       input logic [2:0] alu, input logic alu_src,
                       input logic rw, input logic mw, input logic [1:0] rsrc);
    id_valid = 1'b1; id_rs1 = rs1; id_rd1 = rd1; id_rs2 = rs2; id_rd2 = rd2;
    id_imm_ext = imm; id_rd = rd; id_alu_control = alu; id_alu_src = alu_src;
    id_reg_write = rw; id_mem_write = mw; id_result_src = rsrc;
  endtask

  task automatic drain();
    @(negedge clk); set_idle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); set_idle(); reset_n = 1'b0;
    @(negedge clk); set_idle();
    exp_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0; id_valid = 1'b1; id_rs1 = 5'd5; id_rd1 = 32'hDEAD; id_rd = 5'd9;
    id_reg_write = 1'b1; id_mem_write = 1'b1; id_alu_control = 3'b111;
    mem_reg_write = 1'b1; mem_rd = 5'd5; mem_alu_result = 32'hFFFF_FFFF; mem_is_load = 1'b1;
    @(negedge clk); #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset ex_valid got=%b exp=0", ex_valid); end
    total++; if (SrcA !== 32'h0) begin bad++; $display("FAIL reset SrcA got=%h exp=0", SrcA); end
    total++; if (SrcB !== 32'h0) begin bad++; $display("FAIL reset SrcB got=%h exp=0", SrcB); end
    total++; if (ex_write_data !== 32'h0) begin bad++; $display("FAIL reset wdata got=%h exp=0", ex_write_data); end
    total++; if (ALUControl !== 3'b000) begin bad++; $display("FAIL reset ALUControl got=%b exp=000", ALUControl); end
    total++; if (ex_rd !== 5'd0) begin bad++; $display("FAIL reset ex_rd got=%0d exp=0", ex_rd); end
    total++; if ({ex_reg_write, ex_mem_write, ex_result_src} !== 4'b0) begin
      bad++; $display("FAIL reset controls got=%b%b%b exp=0000", ex_reg_write, ex_mem_write, ex_result_src); end
    set_idle(); #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL reset id_ready got=%b exp=1", id_ready); end
  endtask

  task automatic test_mem_priority();
    @(negedge clk); set_idle(); ex_ready = 1'b0;
    issue(5'd5, 32'h99, 5'd0, 32'h0, 32'h0, 5'd1, 3'b000, 1'b0, 1'b1, 1'b0, 2'b00);
    @(negedge clk); id_valid = 1'b0;
    mem_reg_write = 1'b1; mem_rd = 5'd5; mem_alu_result = 32'h10;
    wb_reg_write = 1'b1; wb_rd = 5'd5; wb_result = 32'h20; #1;
    total++; if (SrcA !== 32'h10) begin bad++; $display("FAIL mem_prio SrcA got=%h exp=10", SrcA); end
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL mem_prio ex_valid got=%b exp=1", ex_valid); end
    mem_reg_write = 1'b0; #1;
    total++; if (SrcA !== 32'h20) begin bad++; $display("FAIL wb_fwd SrcA got=%h exp=20", SrcA); end
    wb_reg_write = 1'b0; #1;
    total++; if (SrcA !== 32'h99) begin bad++; $display("FAIL no_fwd SrcA got=%h exp=99", SrcA); end
    drain();
  endtask

  task automatic test_x0();
    @(negedge clk); set_idle(); ex_ready = 1'b0;
    issue(5'd0, 32'h1234, 5'd0, 32'h5678, 32'h0, 5'd2, 3'b010, 1'b0, 1'b1, 1'b0, 2'b00);
    @(negedge clk); id_valid = 1'b0;
    mem_reg_write = 1'b1; mem_rd = 5'd0; mem_alu_result = 32'hFFFF;
    wb_reg_write = 1'b1; wb_rd = 5'd0; wb_result = 32'hEEEE; #1;
    total++; if (SrcA !== 32'h1234) begin bad++; $display("FAIL x0 SrcA got=%h exp=1234", SrcA); end
    total++; if (ex_write_data !== 32'h5678) begin bad++; $display("FAIL x0 wdata got=%h exp=5678", ex_write_data); end
    drain();
  endtask

  task automatic test_load_use();
    @(negedge clk); set_idle();
    issue(5'd1, 32'h11, 5'd7, 32'h22, 32'h0, 5'd9, 3'b000, 1'b0, 1'b1, 1'b0, 2'b00);
    @(negedge clk); id_valid = 1'b0;
    mem_is_load = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd7; mem_alu_result = 32'h1000; #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL load_use ex_valid got=%b exp=0", ex_valid); end
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL load_use id_ready got=%b exp=0", id_ready); end
    total++; if (ex_reg_write !== 1'b0) begin bad++; $display("FAIL load_use reg_write got=%b exp=0", ex_reg_write); end
    @(negedge clk);
    mem_is_load = 1'b0; mem_reg_write = 1'b0; mem_rd = 5'd0;
    wb_reg_write = 1'b1; wb_rd = 5'd7; wb_result = 32'hCAFE; #1;
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL after_lu ex_valid got=%b exp=1", ex_valid); end
    total++; if (SrcB !== 32'hCAFE) begin bad++; $display("FAIL after_lu SrcB got=%h exp=cafe", SrcB); end
    total++; if (ex_write_data !== 32'hCAFE) begin bad++; $display("FAIL after_lu wdata got=%h exp=cafe", ex_write_data); end
    total++; if (SrcA !== 32'h11) begin bad++; $display("FAIL after_lu SrcA got=%h exp=11", SrcA); end
    total++; if (ex_rd !== 5'd9) begin bad++; $display("FAIL after_lu ex_rd got=%0d exp=9", ex_rd); end
    @(negedge clk); set_idle(); #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL after_lu drained got=%b exp=0", ex_valid); end
  endtask

  task automatic test_stall();
    @(negedge clk); set_idle(); ex_ready = 1'b0;
    issue(5'd3, 32'h01, 5'd0, 32'h0, 32'h0, 5'd4, 3'b001, 1'b0, 1'b1, 1'b0, 2'b00);
    @(negedge clk); id_valid = 1'b0;
    mem_reg_write = 1'b1; mem_rd = 5'd3; mem_alu_result = 32'h55; #1;
    total++; if (SrcA !== 32'h55) begin bad++; $display("FAIL stall_mem SrcA got=%h exp=55", SrcA); end
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL stall id_ready got=%b exp=0", id_ready); end
    @(negedge clk); mem_reg_write = 1'b0; mem_rd = 5'd0;
    wb_reg_write = 1'b1; wb_rd = 5'd3; wb_result = 32'h55; #1;
    total++; if (SrcA !== 32'h55) begin bad++; $display("FAIL stall_wb SrcA got=%h exp=55", SrcA); end
    @(negedge clk); wb_reg_write = 1'b0; wb_rd = 5'd0; #1;
    total++; if (SrcA !== 32'h55) begin bad++; $display("FAIL stall_retired SrcA got=%h exp=55", SrcA); end
    @(negedge clk); ex_ready = 1'b1; #1;
    total++; if (SrcA !== 32'h55 || ex_valid !== 1'b1) begin
      bad++; $display("FAIL stall_fire SrcA/valid got=%h/%b exp=55/1", SrcA, ex_valid); end
    @(negedge clk); set_idle(); #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL stall drained got=%b exp=0", ex_valid); end
  endtask

  task automatic test_flush();
    @(negedge clk); set_idle(); flush_e = 1'b1;
    issue(5'd2, 32'hAB, 5'd0, 32'h0, 32'h0, 5'd4, 3'b011, 1'b0, 1'b1, 1'b0, 2'b00); #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL flush id_ready got=%b exp=1", id_ready); end
    @(negedge clk); set_idle(); #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_id ex_valid got=%b exp=0", ex_valid); end
    total++; if (ex_reg_write !== 1'b0) begin bad++; $display("FAIL flush_id reg_write got=%b exp=0", ex_reg_write); end
    // flush of an instruction already held while downstream is busy
    @(negedge clk); ex_ready = 1'b0;
    issue(5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd6, 3'b000, 1'b0, 1'b1, 1'b0, 2'b00);
    @(negedge clk); flush_e = 1'b1;
    issue(5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd8, 3'b000, 1'b0, 1'b1, 1'b0, 2'b00); #1;
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL flush_held pre got=%b exp=1", ex_valid); end
    @(negedge clk); set_idle(); ex_ready = 1'b0; #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_held ex_valid got=%b exp=0", ex_valid); end
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL flush_held id_ready got=%b exp=1", id_ready); end
    drain();
  endtask

  task automatic test_reset_load_use();
    @(negedge clk); set_idle();
    issue(5'd7, 32'h70, 5'd0, 32'h0, 32'h44, 5'd2, 3'b001, 1'b1, 1'b1, 1'b0, 2'b01);
    @(negedge clk); id_valid = 1'b0;
    mem_is_load = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd7; mem_alu_result = 32'h2000; #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL rst_lu stalled got=%b exp=0", ex_valid); end
    reset_n = 1'b0;
    @(negedge clk); #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL rst_lu ex_valid got=%b exp=0", ex_valid); end
    total++; if ({SrcA, SrcB, ex_write_data} !== {3*XLEN{1'b0}}) begin
      bad++; $display("FAIL rst_lu operands got=%h/%h/%h exp=0", SrcA, SrcB, ex_write_data); end
    total++; if ({ALUControl, ex_rd, ex_reg_write, ex_mem_write, ex_result_src} !== 12'h0) begin
      bad++; $display("FAIL rst_lu controls got=%b/%0d/%b/%b/%b exp=0", ALUControl, ex_rd, ex_reg_write, ex_mem_write, ex_result_src); end
    reset_n = 1'b1; #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL rst_lu id_ready got=%b exp=1", id_ready); end
    @(negedge clk); set_idle();
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] v;
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); set_idle();
      if (k < 4) begin
        v = $urandom;
        issue(5'd0, v, 5'd0, 32'h0, 32'h0, 5'(10 + k), 3'b000, 1'b0, 1'b1, 1'b0, 2'b00);
      end
      #1;
      total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL b2b id_ready k=%0d got=%b exp=1", k, id_ready); end
      if (k > 0) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL b2b queue empty k=%0d", k); end
        else begin
          v = exp_q.pop_front();
          if (SrcA !== v || ex_rd !== 5'(9 + k) || ex_valid !== 1'b1) begin
            bad++; $display("FAIL b2b k=%0d got=%h/%0d/%b exp=%h/%0d/1", k, SrcA, ex_rd, ex_valid, v, 9 + k);
          end
        end
      end
      if (k < 4) exp_q.push_back(id_rd1);
    end
    @(negedge clk); set_idle();
  endtask

  task automatic test_random(input int n);
    logic [XLEN-1:0] e_b, tag;
    do_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      id_valid = ($urandom_range(0, 9) < 7);
      id_rd1 = $urandom; id_rd2 = $urandom; id_imm_ext = $urandom;
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 31)); id_alu_control = 3'($urandom_range(0, 7));
      id_alu_src = 1'($urandom_range(0, 1)); id_reg_write = 1'($urandom_range(0, 1));
      id_mem_write = 1'($urandom_range(0, 1)); id_result_src = 2'($urandom_range(0, 3));
      flush_e = ($urandom_range(0, 9) == 0); ex_ready = ($urandom_range(0, 9) < 7);
      mem_reg_write = 1'($urandom_range(0, 1)); mem_rd = 5'($urandom_range(0, 7));
      mem_alu_result = $urandom; mem_is_load = ($urandom_range(0, 3) == 0);
      wb_reg_write = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 7)); wb_result = $urandom;
      #1;
      e_b = m_alu_src ? m_imm : m_fwd(m_rs2, m_rd2);
      total++; if (ex_valid !== m_ex_valid()) begin bad++; $display("FAIL rnd ex_valid i=%0d got=%b exp=%b", i, ex_valid, m_ex_valid()); end
      total++; if (id_ready !== m_id_ready()) begin bad++; $display("FAIL rnd id_ready i=%0d got=%b exp=%b", i, id_ready, m_id_ready()); end
      total++; if (SrcA !== m_fwd(m_rs1, m_rd1)) begin bad++; $display("FAIL rnd SrcA i=%0d got=%h exp=%h", i, SrcA, m_fwd(m_rs1, m_rd1)); end
      total++; if (SrcB !== e_b) begin bad++; $display("FAIL rnd SrcB i=%0d got=%h exp=%h", i, SrcB, e_b); end
      total++; if (ex_write_data !== m_fwd(m_rs2, m_rd2)) begin bad++; $display("FAIL rnd wdata i=%0d got=%h exp=%h", i, ex_write_data, m_fwd(m_rs2, m_rd2)); end
      total++; if ({ALUControl, ex_rd, ex_result_src} !== {m_alu, m_rd, m_res}) begin
        bad++; $display("FAIL rnd fields i=%0d got=%b/%0d/%b exp=%b/%0d/%b", i, ALUControl, ex_rd, ex_result_src, m_alu, m_rd, m_res); end
      total++; if ({ex_reg_write, ex_mem_write} !== {m_rw && m_ex_valid(), m_mw && m_ex_valid()}) begin
        bad++; $display("FAIL rnd writes i=%0d got=%b%b exp=%b%b", i, ex_reg_write, ex_mem_write, m_rw && m_ex_valid(), m_mw && m_ex_valid()); end
      // scoreboard: each accepted instruction leaves exactly once unless flushed
      if (ex_valid && ex_ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rnd sb unexpected fire i=%0d rd=%0d", i, ex_rd); end
        else begin
          tag = exp_q.pop_front();
          if (XLEN'(ex_rd) !== tag) begin bad++; $display("FAIL rnd sb i=%0d got=%0d exp=%0d", i, ex_rd, tag); end
        end
      end
      if (flush_e) exp_q.delete();
      else if (id_valid && m_id_ready()) exp_q.push_back(XLEN'(id_rd));
    end
    drain();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    set_idle();
    reset_n = 1'b0;
    test_reset();
    test_mem_priority();
    test_x0();
    test_load_use();
    test_stall();
    test_flush();
    test_reset_load_use();
    test_back_to_back();
    test_random(400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have id_valid  input  1 and id_ready  output  1, decode-to-execute handshake.
REQ-005 SHALL have id_rd1, id_rd2, id_imm_ext  input  XLEN  register-file operands and extended immediate.
REQ-006 SHALL have id_rs1, id_rs2, id_rd  input  5  source and destination register indices.
REQ-007 SHALL have id_alu_control  input  3; id_alu_src  input  1; id_reg_write  input  1; id_mem_write  input  1; id_result_src  input  2.
REQ-008 SHALL have flush_e  input  1  kill the held instruction (branch/jump taken).
REQ-009 SHALL have ex_ready  input  1  downstream accepts the current EX instruction.
REQ-010 SHALL have mem_reg_write  input  1, mem_rd  input  5, mem_alu_result  input  XLEN, mem_is_load  input  1, all MEM-stage forwarding sources.
REQ-011 SHALL have wb_reg_write  input  1, wb_rd  input  5, wb_result  input  XLEN, all WB-stage forwarding sources.
REQ-012 SHALL have ex_valid  output  1; SrcA, SrcB, ex_write_data  output  XLEN; ALUControl  output  3; ex_rd  output  5; ex_reg_write, ex_mem_write  output  1; ex_result_src  output  2.

Function
REQ-013 SHALL capture all id_* fields and set valid_reg on a cycle where id_valid && id_ready && !flush_e.
REQ-014 SHALL drive id_ready = !valid_reg || (ex_valid && ex_ready), combinationally.
REQ-015 SHALL clear valid_reg on flush_e, with priority over capture and hold; flush_e discards any concurrent ID transfer.
REQ-016 SHALL clear valid_reg when the instruction fires (ex_valid && ex_ready) and no new capture occurs.
REQ-017 SHALL forward per operand with priority MEM over WB over stored value; a source matches only when the stage's reg_write=1, its rd equals the source index, and the index is nonzero (x0 is never forwarded).
REQ-018 SHALL drive SrcA = forwarded rs1 value, SrcB = id_alu_src_reg ? imm_reg : forwarded rs2 value, and ex_write_data = forwarded rs2 value.
REQ-019 SHALL detect load-use when valid_reg && mem_is_load && mem_reg_write && mem_rd != 0 && mem_rd equals rs1_reg or rs2_reg (rs2 only when alu_src=0 or mem_write=1).
REQ-020 SHALL, while load-use holds, force ex_valid=0 and id_ready=0 and retain the instruction; the next cycle it forwards from WB with no further bubble.
REQ-021 SHALL drive ex_valid = valid_reg && !load_use.
REQ-022 SHALL, on every cycle valid_reg=1 without fire or flush, overwrite stored rd1/rd2 with their forwarded values, so stalled instructions never lose a retiring producer's result.
REQ-023 SHALL pass ALUControl, ex_rd, ex_reg_write, ex_mem_write and ex_result_src directly from the held registers; ex_reg_write and ex_mem_write are gated by ex_valid.

Reset
REQ-024 SHALL, on a clk edge with reset_n=0, clear valid_reg and all stored fields to 0, giving ex_valid=0, SrcA=SrcB=ex_write_data=0, ALUControl=000, ex_rd=0, and all controls 0.
REQ-025 SHALL drive id_ready=1 during the first cycle after reset release.
REQ-026 SHALL, when reset is asserted mid-stall or mid-load-use, drop the held instruction with no output glitch beyond that cycle.

Structure
REQ-027 SHALL take the ALU control encoding (ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101, SRL 110, SLL 111), the result_src encoding and the forward-select enum (FWD_REG, FWD_WB, FWD_MEM) from shared package riscv_pkg.
REQ-028 SHALL implement operand selection in one sub-module, forward_unit, instantiated once per source operand.

Verification
REQ-029 SHALL test: MEM rd=5 holds 0x10, WB rd=5 holds 0x20, EX rs1=5 -> SrcA=0x10 (MEM priority).
REQ-030 SHALL test: EX rs1=0, MEM rd=0 with reg_write=1 and result 0xFFFF -> SrcA = stored rd1 (x0 not forwarded).
REQ-031 SHALL test: load to x7 in MEM, EX add rs2=7 -> one cycle ex_valid=0 and id_ready=0, next cycle SrcB=wb_result=0xCAFE and ex_valid=1.
REQ-032 SHALL test: ex_ready=0 for 3 cycles while producer x3=0x55 passes MEM then WB then retires -> SrcA=0x55 on the fire cycle.
REQ-033 SHALL test: flush_e=1 with id_valid=1 -> next cycle ex_valid=0 and the ID instruction is discarded.
REQ-034 SHALL test: reset_n=0 during a load-use stall -> next cycle ex_valid=0, all outputs 0, id_ready=1 after release.
